// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: FSM state encoding, refresh sub-phases,
// access size codes and a small index-width helper.
package vram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE,
    ST_REFRESH
  } arb_state_e;

  typedef enum logic [1:0] {
    RF_STROBE,
    RF_WAIT_HI,
    RF_WAIT_LO
  } rf_phase_e;

  typedef enum logic [1:0] {
    WS_BYTE,
    WS_HALF,
    WS_WORD,
    WS_RSVD
  } word_size_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vram_arbiter_rr_grant.sv
// Round-robin grant picker: searches from the port after last_idx, wrapping.
// With PORT0_PRIO set, port 0 wins outright and the others rotate among themselves.
module rr_grant
  import vram_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter bit PORT0_PRIO = 1'b0,
  localparam int IW        = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        last_idx,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IW-1:0]        gnt_idx,
  output logic                 gnt_valid
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    if (PORT0_PRIO && req[0]) begin
      gnt[0]    = 1'b1;
      gnt_valid = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        cand = IW'((int'(last_idx) + k) % NUM_PORTS);
        if (!gnt_valid && req[cand]) begin
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
          gnt_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Multi-port VRAM access arbiter with periodic refresh insertion.
// Optional build macro PORT0_PRIORITY_EN gives port 0 (display fetch) absolute priority.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NUM_PORTS        = 3,
  parameter int ADDR_WIDTH       = 17,
  parameter int REFRESH_INTERVAL = 810
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 req,
  input  logic [NUM_PORTS-1:0]                 wr,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS-1:0][1:0]            word_size,
  input  logic [NUM_PORTS-1:0][31:0]           din32,
  output logic [NUM_PORTS-1:0]                 ack,
  output logic [31:0]                          dout32,
  output logic                                 mem_read,
  output logic                                 mem_write,
  output logic                                 mem_refresh,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [31:0]                          mem_din32,
  output logic [1:0]                           mem_word_size,
  input  logic                                 mem_busy,
  input  logic [31:0]                          mem_dout32,
  output logic                                 refresh_overrun
);

  localparam int IW = idx_w(NUM_PORTS);
  localparam int CW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_INTERVAL - 1);
`ifdef PORT0_PRIORITY_EN
  localparam bit P0_PRIO = 1'b1;
`else
  localparam bit P0_PRIO = 1'b0;
`endif

  arb_state_e                 state_q, state_d;
  rf_phase_e                  rf_phase_q, rf_phase_d;
  logic [NUM_PORTS-1:0]       grant_q, grant_d;
  logic [IW-1:0]              last_q, last_d;
  logic                       wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [31:0]                din_q, din_d;
  word_size_e                 ws_q, ws_d;
  logic [NUM_PORTS-1:0]       ack_q, ack_d;
  logic [31:0]                dout_q, dout_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       pend_q, pend_d;
  logic                       ovr_q, ovr_d;
  logic                       rf_clear, wrap;

  logic [NUM_PORTS-1:0]       elig;
  logic [NUM_PORTS-1:0]       gnt;
  logic [IW-1:0]              gnt_idx;
  logic                       gnt_valid;

  // A requester still shows req in its ack cycle; hold off all new grants for
  // that one cycle so it is never served twice and so it can re-request first.
  assign elig = (|ack_q) ? '0 : req;

  rr_grant #(
    .NUM_PORTS (NUM_PORTS),
    .PORT0_PRIO(P0_PRIO)
  ) u_rr_grant (
    .req      (elig),
    .last_idx (last_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always_comb begin
    state_d    = state_q;
    rf_phase_d = rf_phase_q;
    grant_d    = grant_q;
    last_d     = last_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    din_d      = din_q;
    ws_d       = ws_q;
    ack_d      = '0;
    dout_d     = dout_q;
    rf_clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!mem_busy) begin
          if (pend_q) begin
            state_d    = ST_REFRESH;
            rf_phase_d = RF_STROBE;
          end else if (gnt_valid) begin
            grant_d = gnt;
            wr_d    = wr[gnt_idx];
            addr_d  = addr[gnt_idx];
            din_d   = din32[gnt_idx];
            ws_d    = word_size_e'(word_size[gnt_idx]);
            // Priority grants to port 0 do not disturb the rotation of the others.
            if (!(P0_PRIO && gnt_idx == '0)) last_d = gnt_idx;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT_ACCEPT;
      ST_WAIT_ACCEPT: begin
        if (mem_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!mem_busy) begin
          ack_d   = grant_q;
          dout_d  = mem_dout32;
          state_d = ST_IDLE;
        end
      end
      ST_REFRESH: begin
        case (rf_phase_q)
          RF_STROBE: begin
            rf_clear   = 1'b1;
            rf_phase_d = RF_WAIT_HI;
          end
          RF_WAIT_HI: begin
            if (mem_busy) rf_phase_d = RF_WAIT_LO;
          end
          default: begin
            if (!mem_busy) state_d = ST_IDLE;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A wrap in the same cycle as the refresh strobe re-arms pending and is not an overrun.
  always_comb begin
    wrap   = (cnt_q == CNT_LAST);
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    pend_d = wrap | (pend_q & ~rf_clear);
    ovr_d  = ovr_q | (wrap & pend_q & ~rf_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rf_phase_q <= RF_STROBE;
      grant_q    <= '0;
      last_q     <= IW'(NUM_PORTS - 1);
      wr_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      ws_q       <= WS_BYTE;
      ack_q      <= '0;
      dout_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_phase_q <= rf_phase_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ws_q       <= ws_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ack             = ack_q;
  assign dout32          = dout_q;
  assign mem_read        = (state_q == ST_ISSUE) & ~wr_q;
  assign mem_write       = (state_q == ST_ISSUE) & wr_q;
  assign mem_refresh     = (state_q == ST_REFRESH) & (rf_phase_q == RF_STROBE);
  assign mem_addr        = addr_q;
  assign mem_din32       = din_q;
  assign mem_word_size   = ws_q;
  assign refresh_overrun = ovr_q;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of requester ports (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 17, VRAM address width.
REQ-003 SHALL have parameter REFRESH_INTERVAL, default 810, clk cycles between refresh requests.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port req  input  NUM_PORTS  per-port request, held high until ack.
REQ-007 SHALL have port wr  input  NUM_PORTS  per-port write (1) / read (0) qualifier.
REQ-008 SHALL have port addr  input  NUM_PORTS x ADDR_WIDTH  per-port address.
REQ-009 SHALL have port word_size  input  NUM_PORTS x 2  per-port access size code.
REQ-010 SHALL have port din32  input  NUM_PORTS x 32  per-port write data.
REQ-011 SHALL have port ack  output  NUM_PORTS  one-cycle completion pulse per port.
REQ-012 SHALL have port dout32  output  32  read data, valid in the ack cycle.
REQ-013 SHALL have ports mem_read, mem_write, mem_refresh  output  1 each  controller strobes.
REQ-014 SHALL have ports mem_addr  output  ADDR_WIDTH; mem_din32  output  32; mem_word_size  output  2.
REQ-015 SHALL have ports mem_busy  input  1; mem_dout32  input  32  controller status and read data.
REQ-016 SHALL have port refresh_overrun  output  1  sticky flag, refresh interval expired while one pending.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, REFRESH.
REQ-018 IDLE: with refresh pending and mem_busy low SHALL go REFRESH; else with any req high and mem_busy low SHALL latch grant, addr, wr, word_size, din32 and go ISSUE.
REQ-019 ISSUE SHALL assert exactly one of mem_read/mem_write for one cycle, then go WAIT_ACCEPT.
REQ-020 WAIT_ACCEPT SHALL go WAIT_DONE when mem_busy is high; WAIT_DONE SHALL, on mem_busy low, pulse ack[grant], register mem_dout32 into dout32 and return to IDLE.
REQ-021 REFRESH SHALL assert mem_refresh one cycle, clear the pending flag, wait for mem_busy high then low, return to IDLE.
REQ-022 Grant SHALL be round-robin: search starts at port after last granted, wrapping NUM_PORTS-1 to 0.
REQ-023 Refresh counter SHALL count 0..REFRESH_INTERVAL-1, wrap, and set pending at wrap; counting continues in all states.
REQ-024 Refresh pending SHALL take priority over new grants but SHALL never abort an in-progress access.
REQ-025 Counter wrap while pending already set SHALL set refresh_overrun; pending stays single (no queueing).
REQ-026 Refresh-clear and new-wrap in same cycle SHALL leave pending set.
REQ-027 Requester deasserting req before ack SHALL not abort the latched access; ack still pulses.
REQ-028 Minimum access latency: req high in IDLE to ack SHALL be 4 cycles with one-cycle controller busy.
REQ-029 mem_addr, mem_din32, mem_word_size SHALL hold latched values from ISSUE through WAIT_DONE.

Reset
REQ-030 Reset SHALL force IDLE, ack=0, dout32=0, all mem strobes 0, mem_addr/din32/word_size 0, refresh counter 0, pending 0, refresh_overrun 0, last-grant pointer NUM_PORTS-1.
REQ-031 Reset mid-access SHALL drop the access without ack; requesters re-request.

Configuration
REQ-032 With PORT0_PRIORITY_EN defined, port 0 SHALL win over all other ports whenever requesting (display fetch), round-robin among the rest.
REQ-033 Without PORT0_PRIORITY_EN, all ports including 0 SHALL share pure round-robin.

Structure
REQ-034 State enum and word_size codes SHALL live in shared package vram_arb_pkg.
REQ-035 Grant selection SHALL be sub-module rr_grant (NUM_PORTS, req, last pointer, priority option -> one-hot grant, index).

Verification
REQ-036 Single read port 1 addr 0x1234, mem_busy high 1 cycle, mem_dout32 0xDEADBEEF -> ack[1] at cycle 4, dout32 0xDEADBEEF.
REQ-037 Ports 0,1,2 held requesting, no priority macro -> grant order 0,1,2,0,1,2.
REQ-038 PORT0_PRIORITY_EN, ports 0 and 2 held -> port 0 granted every arbitration until released, then port 2.
REQ-039 REFRESH_INTERVAL 16, continuous requests -> mem_refresh once per 16 cycles, never during WAIT_DONE.
REQ-040 mem_busy held high 40 cycles, REFRESH_INTERVAL 16 -> refresh_overrun set and sticky until reset.
REQ-041 Reset during WAIT_DONE -> no ack, all outputs zero next cycle, new request served normally.
